// File: rtl/dds_controller.sv
// DDS controller: phase accumulator driving a waveform ROM address,
// with continuous and burst modes plus DAC clock/blank/sync strobes.
module dds_controller #(
  parameter int ACC_W   = 16,
  parameter int ADDR_W  = 5,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               enable,
  input  logic               mode,
  input  logic [ACC_W-1:0]   freq_word,
  input  logic [ADDR_W-1:0]  phase_offset,
  input  logic [BURST_W-1:0] burst_len,
  output logic [ADDR_W-1:0]  address,
  output logic               clk_DA,
  output logic               blank_DA_n,
  output logic               sync_DA_n,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_n;

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   fw_q;
  logic [ADDR_W-1:0]  offset_q;
  logic               mode_q;
  logic [BURST_W-1:0] blen_q;
  logic [BURST_W-1:0] wcnt_q;
  logic               sync_q;

  logic [ACC_W:0]     sum;
  logic [BURST_W-1:0] wcnt_inc;
  logic               accept;
  logic               adv;
  logic               wrap;
  logic               last_wrap;

  assign sum      = {1'b0, acc_q} + {1'b0, fw_q};
  assign wcnt_inc = wcnt_q + BURST_W'(1);

  // a zero-length burst would never finish, so such a start is dropped
  assign accept = (state_q == IDLE) && start && !stop
                && !(mode && (burst_len == '0));

  assign adv       = (state_q == RUN) && enable && !stop;
  assign wrap      = adv && sum[ACC_W];
  assign last_wrap = wrap && mode_q && (wcnt_inc == blen_q);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: if (accept) state_n = RUN;
      RUN: begin
        if (stop)           state_n = IDLE;
        else if (last_wrap) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      fw_q     <= '0;
      offset_q <= '0;
      mode_q   <= 1'b0;
      blen_q   <= '0;
      wcnt_q   <= '0;
      sync_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      sync_q  <= wrap;
      if (accept) begin
        acc_q    <= '0;
        fw_q     <= freq_word;
        offset_q <= phase_offset;
        mode_q   <= mode;
        blen_q   <= burst_len;
        wcnt_q   <= '0;
      end else if (adv) begin
        // leaving RUN parks the accumulator at zero
        acc_q <= last_wrap ? '0 : sum[ACC_W-1:0];
        if (wrap) begin
          fw_q <= freq_word;
          if (mode_q) wcnt_q <= wcnt_inc;
        end
      end else if ((state_q == RUN) && stop) begin
        acc_q <= '0;
      end
    end
  end

  assign address    = acc_q[ACC_W-1 -: ADDR_W] + offset_q;
  assign clk_DA     = clk;
  assign blank_DA_n = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign sync_DA_n  = ~sync_q;

endmodule

// File: tb/tb_dds_controller.sv
// Directed self-checking bench for dds_controller.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_dds_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        enable;
  logic        mode;
  logic [15:0] freq_word;
  logic [4:0]  phase_offset;
  logic [7:0]  burst_len;
  logic [4:0]  address;
  logic        clk_DA;
  logic        blank_DA_n;
  logic        sync_DA_n;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;
  int nbusy;
  int nsync;

  dds_controller #(.ACC_W(16), .ADDR_W(5), .BURST_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .enable(enable),
    .mode(mode),
    .freq_word(freq_word),
    .phase_offset(phase_offset),
    .burst_len(burst_len),
    .address(address),
    .clk_DA(clk_DA),
    .blank_DA_n(blank_DA_n),
    .sync_DA_n(sync_DA_n),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag, input int exp_addr);
    chk({tag, "_addr"},  int'(address),    exp_addr);
    chk({tag, "_blank"}, int'(blank_DA_n), 0);
    chk({tag, "_sync"},  int'(sync_DA_n),  1);
    chk({tag, "_busy"},  int'(busy),       0);
    chk({tag, "_done"},  int'(done),       0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    enable       = 1'b1;
    mode         = 1'b0;
    freq_word    = 16'h0000;
    phase_offset = 5'd0;
    burst_len    = 8'd0;
    step();
    step();
    chk_idle_outs("reset", 0);
    chk("clk_DA", int'(clk_DA), 1);
    reset = 1'b0;
    step();

    // continuous sweep: 0..31 then wrap to 0 with a sync pulse
    freq_word = 16'h0800;
    do_start();
    chk("sweep_busy0", int'(busy), 1);
    chk("sweep_blank0", int'(blank_DA_n), 1);
    chk("sweep_addr0", int'(address), 0);
    chk("sweep_sync0", int'(sync_DA_n), 1);
    for (int k = 1; k <= 33; k++) begin
      step();
      chk("sweep_addr", int'(address), k % 32);
      chk("sweep_sync", int'(sync_DA_n), (k == 32) ? 0 : 1);
      chk("sweep_busy", int'(busy), 1);
    end
    do_stop();
    chk_idle_outs("sweep_stop", 0);

    // offset 5, step 2, retune to step 1 at the next wrap
    phase_offset = 5'd5;
    freq_word    = 16'h1000;
    do_start();
    chk("ofs_addr0", int'(address), 5);
    step();
    chk("ofs_addr1", int'(address), 7);
    step();
    chk("ofs_addr2", int'(address), 9);
    freq_word = 16'h0800;
    for (int k = 3; k <= 19; k++) begin
      step();
      chk("retune_addr", int'(address),
          (k <= 16) ? ((5 + 2 * (k % 16)) % 32) : (5 + k - 16));
      chk("retune_sync", int'(sync_DA_n), (k == 16) ? 0 : 1);
    end
    do_stop();
    chk_idle_outs("ofs_stop", 5);

    // pause for 10 cycles, then resume
    phase_offset = 5'd0;
    freq_word    = 16'h0800;
    do_start();
    step();
    step();
    step();
    chk("pause_pre", int'(address), 3);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("pause_addr", int'(address), 3);
      chk("pause_sync", int'(sync_DA_n), 1);
      chk("pause_busy", int'(busy), 1);
    end
    enable = 1'b1;
    step();
    chk("resume_addr", int'(address), 4);
    step();
    chk("resume_addr2", int'(address), 5);
    do_stop();

    // burst of 3 periods
    mode      = 1'b1;
    burst_len = 8'd3;
    do_start();
    nbusy = 0;
    nsync = 0;
    for (int k = 0; k <= 96; k++) begin
      if (k > 0) step();
      if (busy) nbusy++;
      if (!sync_DA_n) nsync++;
    end
    chk("burst_busy_cycles", nbusy, 96);
    chk("burst_sync_count", nsync, 3);
    chk("burst_done", int'(done), 1);
    chk("burst_blank", int'(blank_DA_n), 0);
    step();
    chk_idle_outs("burst_after", 0);

    // stop coincides with the final wrap
    burst_len = 8'd2;
    do_start();
    for (int k = 1; k <= 63; k++) step();
    chk("stopwrap_pre_busy", int'(busy), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stopwrap_done", int'(done), 0);
    chk("stopwrap_busy", int'(busy), 0);
    step();
    chk("stopwrap_done2", int'(done), 0);

    // zero-length burst start is ignored
    burst_len = 8'd0;
    do_start();
    chk("blen0_busy", int'(busy), 0);
    step();
    chk("blen0_busy2", int'(busy), 0);

    // start and stop together in IDLE
    mode  = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    step();
    chk("startstop_busy2", int'(busy), 0);

    // reset at cycle 40 of a burst, then a fresh burst
    mode         = 1'b1;
    burst_len    = 8'd3;
    phase_offset = 5'd7;
    do_start();
    for (int k = 1; k <= 39; k++) step();
    chk("rst_pre_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle_outs("rst_mid", 0);
    phase_offset = 5'd0;
    do_start();
    nbusy = 0;
    nsync = 0;
    for (int k = 0; k <= 96; k++) begin
      if (k > 0) step();
      if (busy) nbusy++;
      if (!sync_DA_n) nsync++;
    end
    chk("fresh_busy_cycles", nbusy, 96);
    chk("fresh_sync_count", nsync, 3);
    chk("fresh_done", int'(done), 1);
    step();
    chk("fresh_done_clr", int'(done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dds_controller.md
DDS_CONTROLLER -- requirements
Module: dds_controller

Interface
REQ-001 Parameter ACC_W, default 16, phase accumulator width in bits.
REQ-002 Parameter ADDR_W, default 5, waveform ROM address width; the block SHALL require ADDR_W <= ACC_W.
REQ-003 Parameter BURST_W, default 8, burst length counter width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin generation.
REQ-007 stop  in  1  abort generation; return to IDLE.
REQ-008 enable  in  1  in RUN, 1 = advance, 0 = hold accumulator (pause).
REQ-009 mode  in  1  0 = continuous, 1 = burst.
REQ-010 freq_word  in  ACC_W  phase increment per cycle.
REQ-011 phase_offset  in  ADDR_W  address offset added to accumulator MSBs.
REQ-012 burst_len  in  BURST_W  number of full periods per burst.
REQ-013 address  out  ADDR_W  waveform ROM address.
REQ-014 clk_DA  out  1  DAC clock, equal to clk.
REQ-015 blank_DA_n  out  1  DAC blank, active low.
REQ-016 sync_DA_n  out  1  DAC sync, active low, marks period start.
REQ-017 busy  out  1  high in RUN.
REQ-018 done  out  1  one-cycle pulse at burst completion.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN: start=1 and stop=0, unless mode=1 and burst_len=0, in which case start is ignored.
- RUN->IDLE: stop=1, with no done pulse.
- RUN->DONE: on the edge producing the burst_len-th wrap in burst mode.
- DONE->IDLE: unconditionally after one cycle.
REQ-020 On start acceptance, the block SHALL latch freq_word, phase_offset, mode and burst_len, clear acc to 0, and clear the wrap count to 0.
REQ-021 In RUN with enable=1, acc SHALL update each cycle as acc <= (acc + fw_q) mod 2^ACC_W; with enable=0, acc, wrap count and address SHALL hold.
REQ-022 A wrap is the carry out of the accumulator addition; on each wrap, fw_q SHALL reload from freq_word so the new frequency takes effect from the next addition, giving glitch-free retuning at period boundaries.
REQ-023 address SHALL equal (acc[ACC_W-1 -: ADDR_W] + offset_q) mod 2^ADDR_W, combinational from registered state with zero added latency; in IDLE and DONE, acc=0, so address = offset_q.
REQ-024 sync_DA_n SHALL be 0 for exactly the one cycle following each wrap edge, and 1 otherwise; it SHALL stay 1 during pause cycles.
REQ-025 blank_DA_n SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-026 busy SHALL be 1 only in RUN.
REQ-027 done SHALL be 1 only in DONE.
REQ-028 In burst mode, the wrap count SHALL increment on each wrap; the wrap reaching burst_len SHALL move the FSM to DONE on that same edge.
REQ-029 Continuous mode SHALL never count wraps toward completion and SHALL run until stop or reset.
REQ-030 start while in RUN or DONE SHALL be ignored.
REQ-031 Simultaneous start and stop in IDLE: stop SHALL win, and the FSM SHALL remain in IDLE.
REQ-032 stop SHALL take priority over a wrap-driven RUN->DONE transition on the same edge.
REQ-033 freq_word=0 SHALL hold address constant in RUN, with no wraps and no sync pulses.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL set state=IDLE, acc=0, fw_q=0, offset_q=0, wrap count=0 and mode_q=0.
REQ-035 Reset values of outputs SHALL be: address=0, blank_DA_n=0, sync_DA_n=1, busy=0, done=0.
REQ-036 Reset SHALL override all inputs, including mid-RUN operation and the DONE state.

Verification
REQ-037 Legacy sweep (ACC_W=16, ADDR_W=5, fw=0x0800, offset=0, mode=0): start -> address counts 0,1,...,31,0; sync_DA_n low once every 32 cycles, coinciding with address=0.
REQ-038 Burst (fw=0x0800, burst_len=3, mode=1): start accepted at edge 0 -> busy high for 96 cycles; 3 sync pulses; done high in the cycle after edge 96; blank_DA_n low from then on.
REQ-039 Offset and retune (offset=5, fw=0x1000): address sequence 5,7,9,...; freq_word changed to 0x0800 mid-period -> step stays 2 until the next wrap, then becomes 1.
REQ-040 Pause (enable held low for 10 cycles in RUN): address and acc hold, no sync pulse; resume continues from the held value.
REQ-041 Boundaries:
- stop on the same edge as the final burst wrap -> IDLE, no done.
- start with burst_len=0 in burst mode -> stays IDLE.
- start+stop together in IDLE -> stays IDLE.
REQ-042 Reset mid-burst (reset=1 at cycle 40) -> next cycle shows all REQ-035 values; a subsequent start runs a full fresh burst.
